// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
// Request and response channels between two requesters and the shared-ALU
// controller. Each requester owns one request channel (valid/ready plus
// operands and opcode) and one response channel (valid/ready plus result).
// The controller connects through the slave modport; the requester side
// (or a bench) connects through the master modport.

interface alu_share_ctrl_if;

  // Requester 0 request channel
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;

  // Requester 1 request channel
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;

  // Requester 0 response channel
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [3:0] rsp0_result;

  // Requester 1 response channel
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [3:0] rsp1_result;

  // Requester side: issues operations and consumes results.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result,
    input  rsp1_valid, rsp1_result
  );

  // Controller side: accepts operations and returns results.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result,
    output rsp1_valid, rsp1_result
  );

endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Round-robin sharing controller for a 4-bit combinational ALU.
// Two requesters compete for the ALU; the winner's operands and opcode are
// registered onto the ALU inputs at the accept edge, the ALU result is
// captured one cycle later into the winner's result register, and the
// result is offered on the winner's response channel until it is taken.
// The ALU input registers only change at an accept edge, so the ALU
// datapath stays quiet while the controller is idle or waiting.

module alu_share_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Controller phases: waiting for a request, ALU evaluating, result offered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;

  // Requester that was granted most recently; the other one wins a tie.
  logic             last_grant_q;
  logic             last_grant_d;
  // Requester whose operation is currently in flight.
  logic             owner_q;
  logic             owner_d;

  // ALU input registers (operand isolation: loaded only on accept).
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_a_d;
  logic [3:0]       alu_b_q;
  logic [3:0]       alu_b_d;
  logic [2:0]       alu_sel_q;
  logic [2:0]       alu_sel_d;

  // Response channel state, one slot per requester.
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_valid_d;
  logic [3:0]       rsp0_result_q;
  logic [3:0]       rsp0_result_d;
  logic [3:0]       rsp1_result_q;
  logic [3:0]       rsp1_result_d;

  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;
  logic             busy_q;
  logic             busy_d;

  // Arbitration and handshake decode.
  logic [1:0]       req_valid_s;
  logic [1:0]       rsp_ready_s;
  logic             grant_vld_s;
  logic             grant_idx_s;
  logic             accept_s;
  logic             rsp_hs_s;
  logic [3:0]       grant_a_s;
  logic [3:0]       grant_b_s;
  logic [2:0]       grant_op_s;

  assign req_valid_s = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready_s = {bus.rsp1_ready, bus.rsp0_ready};

  // Round-robin grant: a lone valid wins, a tie goes to the requester not served last.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 1'b0;
    if (req_valid_s == 2'b11) begin
      grant_vld_s = 1'b1;
      grant_idx_s = ~last_grant_q;
    end else if (req_valid_s[0]) begin
      grant_vld_s = 1'b1;
      grant_idx_s = 1'b0;
    end else if (req_valid_s[1]) begin
      grant_vld_s = 1'b1;
      grant_idx_s = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_idx_s = 1'b0;
    end
  end

  // Select the granted requester's operands and opcode.
  always_comb begin
    grant_a_s  = 4'd0;
    grant_b_s  = 4'd0;
    grant_op_s = 3'd0;
    if (grant_idx_s) begin
      grant_a_s  = bus.req1_a;
      grant_b_s  = bus.req1_b;
      grant_op_s = bus.req1_op;
    end else begin
      grant_a_s  = bus.req0_a;
      grant_b_s  = bus.req0_b;
      grant_op_s = bus.req0_op;
    end
  end

  // Ready is offered only in IDLE and only to the granted requester, so an
  // accept is simply "IDLE with a grant". A response completes when the
  // owner's slot is valid and the owner takes it.
  assign accept_s       = (state_q == ST_IDLE) && grant_vld_s;
  assign bus.req0_ready = accept_s && !grant_idx_s;
  assign bus.req1_ready = accept_s &&  grant_idx_s;
  assign rsp_hs_s       = (state_q == ST_RESP) && rsp_valid_q[owner_q] && rsp_ready_s[owner_q];

  // Next-state and datapath update for every phase of an operation.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rsp_valid_d   = rsp_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    op_count_d    = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          alu_a_d      = grant_a_s;
          alu_b_d      = grant_b_s;
          alu_sel_d    = grant_op_s;
          owner_d      = grant_idx_s;
          last_grant_d = grant_idx_s;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The ALU has had a full cycle to settle on the registered inputs.
        if (owner_q) begin
          rsp1_result_d = alu_out;
        end else begin
          rsp0_result_d = alu_out;
        end
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs_s) begin
          rsp_valid_d[owner_q] = 1'b0;
          op_count_d           = op_count_q + CNT_W'(1);
          state_d              = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        // Unreachable encoding: drop any pending response and recover to IDLE.
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, arbitration history and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_a_q       <= 4'd0;
      alu_b_q       <= 4'd0;
      alu_sel_q     <= 3'd0;
      rsp_valid_q   <= 2'b00;
      rsp0_result_q <= 4'd0;
      rsp1_result_q <= 4'd0;
      op_count_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      op_count_q    <= op_count_d;
      busy_q        <= busy_d;
    end
  end

  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_sel         = alu_sel_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign op_count        = op_count_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
// Directed bench for the shared-ALU controller. The bench models the
// external 4-bit ALU, drives both requesters, and compares the controller's
// outputs against hand-computed values.

module tb_alu_share_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [3:0]       alu_out;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               checks_total  = 0;
  int               checks_passed = 0;
  logic [CNT_W-1:0] exp_cnt;

  alu_share_ctrl_if bus ();

  alu_share_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference behaviour of the 4-bit low-power ALU.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a + ~b + 4'd1;
      3'b010:  r = ~a & b;
      3'b110:  r = a & b;
      3'b100:  r = a ^ b;
      3'b101:  r = {a[2:0], 1'b0};
      3'b011:  r = {1'b0, a[3:1]};
      3'b111:  r = {a[0], a[3:1]};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // External combinational ALU fed by the controller's registered inputs.
  always_comb alu_out = alu_ref(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input logic who, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] op);
    if (who) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  function automatic logic ready_of(input logic who);
    return who ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rsp_valid_of(input logic who);
    return who ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic logic [3:0] rsp_result_of(input logic who);
    return who ? bus.rsp1_result : bus.rsp0_result;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  // One complete operation with the response taken immediately; starts and ends at a negedge in IDLE.
  task automatic single_op(input logic who, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, input logic [3:0] exp);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(who, 1'b1, a, b, op);
    #1;
    check("op_ready",       32'(ready_of(who)),  32'd1);
    check("op_ready_other", 32'(ready_of(~who)), 32'd0);
    @(posedge clk); @(negedge clk);
    drive_req(who, 1'b0, a, b, op);
    check("op_exec_busy",   32'(busy), 32'd1);
    check("op_alu_inputs",  32'({alu_a, alu_b, alu_sel}), 32'({a, b, op}));
    check("op_early_valid", 32'(rsp_valid_of(who)), 32'd0);
    @(posedge clk); @(negedge clk);
    check("op_rsp_valid",   32'(rsp_valid_of(who)), 32'd1);
    check("op_rsp_result",  32'(rsp_result_of(who)), 32'(exp));
    @(posedge clk); @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    check("op_done_valid",  32'(rsp_valid_of(who)), 32'd0);
    check("op_done_busy",   32'(busy), 32'd0);
    check("op_count",       32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rop;

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive_req(1'b1, 1'b0, 4'd0, 4'd0, 3'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req0_ready", 32'(bus.req0_ready),  32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready),  32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid),  32'd0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid),  32'd0);
    check("rst_results",    32'({bus.rsp0_result, bus.rsp1_result}), 32'd0);
    check("rst_alu_inputs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_op_count",   32'(op_count), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    rst = 1'b0;

    // Single operations: 1100+0010 = 1110, 1100-0010 = 1010
    single_op(1'b0, 4'b1100, 4'b0010, 3'b000, 4'b1110);
    single_op(1'b0, 4'b1100, 4'b0010, 3'b001, 4'b1010);

    // Tie right after reset: requester 0 wins first
    do_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive_req(1'b0, 1'b1, 4'b1111, 4'b0001, 3'b000);
    drive_req(1'b1, 1'b1, 4'b0011, 4'b0011, 3'b100);
    #1;
    check("tie_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("tie_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    drive_req(1'b0, 1'b0, 4'b1111, 4'b0001, 3'b000);
    check("tie_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("tie_exec_alu_a",      32'(alu_a), 32'hF);
    @(posedge clk); @(negedge clk);
    check("tie_rsp0_valid",  32'(bus.rsp0_valid),  32'd1);
    check("tie_rsp0_result", 32'(bus.rsp0_result), 32'd0);
    check("tie_rsp1_idle",   32'(bus.rsp1_valid),  32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check("tie_loser_ready", 32'(bus.req1_ready), 32'd1);
    check("tie_count1",      32'(op_count), 32'd1);
    @(posedge clk); @(negedge clk);
    drive_req(1'b1, 1'b0, 4'b0011, 4'b0011, 3'b100);
    check("tie_loser_alu_sel", 32'(alu_sel), 32'b100);
    @(posedge clk); @(negedge clk);
    check("tie_rsp1_valid",  32'(bus.rsp1_valid),  32'd1);
    check("tie_rsp1_result", 32'(bus.rsp1_result), 32'd0);
    @(posedge clk); @(negedge clk);
    check("tie_count2", 32'(op_count), 32'd2);
    check("tie_idle",   32'(busy), 32'd0);
    exp_cnt = 8'd2;

    // Both held valid for 4 ops: grants alternate 0,1,0,1
    drive_req(1'b0, 1'b1, 4'b0001, 4'b0001, 3'b000);
    drive_req(1'b1, 1'b1, 4'b0101, 4'b0011, 3'b100);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_req0_ready", 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_req1_ready", 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("alt_rsp_valid",  32'((k % 2 == 1) ? bus.rsp1_valid : bus.rsp0_valid), 32'd1);
      check("alt_rsp_result", 32'((k % 2 == 1) ? bus.rsp1_result : bus.rsp0_result),
            (k % 2 == 1) ? 32'b0110 : 32'b0010);
      @(posedge clk); @(negedge clk);
    end
    drive_req(1'b0, 1'b0, 4'b0001, 4'b0001, 3'b000);
    drive_req(1'b1, 1'b0, 4'b0101, 4'b0011, 3'b100);
    check("alt_count", 32'(op_count), 32'd6);
    exp_cnt = 8'd6;

    // Back-pressure on requester 1: rotate-right of 1000 is 0100
    bus.rsp1_ready = 1'b0;
    drive_req(1'b1, 1'b1, 4'b1000, 4'b0000, 3'b111);
    #1;
    check("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    drive_req(1'b1, 1'b0, 4'b1000, 4'b0000, 3'b111);
    drive_req(1'b0, 1'b1, 4'b0001, 4'b0001, 3'b000);
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp1_valid",  32'(bus.rsp1_valid),  32'd1);
      check("bp_rsp1_result", 32'(bus.rsp1_result), 32'b0100);
      check("bp_busy",        32'(busy), 32'd1);
      check("bp_req0_ready",  32'(bus.req0_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    bus.rsp1_ready = 1'b1;
    drive_req(1'b0, 1'b0, 4'b0001, 4'b0001, 3'b000);
    @(posedge clk); @(negedge clk);
    check("bp_release_busy",  32'(busy), 32'd0);
    check("bp_release_valid", 32'(bus.rsp1_valid), 32'd0);
    check("bp_release_count", 32'(op_count), 32'd7);
    exp_cnt = 8'd7;

    // Operand isolation: ~0110 & 1001 = 1001, then idle with churning inputs
    single_op(1'b0, 4'b0110, 4'b1001, 3'b010, 4'b1001);
    for (int k = 0; k < 10; k++) begin
      drive_req(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      drive_req(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      @(posedge clk); @(negedge clk);
      check("iso_alu_inputs", 32'({alu_a, alu_b, alu_sel}), 32'({4'b0110, 4'b1001, 3'b010}));
    end

    // 256 consecutive ops over all opcodes: counter wraps to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 3'(i % 8);
      single_op(1'(i % 2), ra, rb, rop, alu_ref(ra, rb, rop));
      if (i == 254) check("wrap_count_max", 32'(op_count), 32'd255);
    end
    check("wrap_count_zero", 32'(op_count), 32'd0);

    // Reset during RESP: response dropped at once, reissue completes
    single_op(1'b1, 4'b0010, 4'b0011, 3'b110, 4'b0010);
    bus.rsp0_ready = 1'b0;
    drive_req(1'b0, 1'b1, 4'b0011, 4'b0100, 3'b000);
    @(posedge clk); @(negedge clk);
    drive_req(1'b0, 1'b0, 4'b0011, 4'b0100, 3'b000);
    @(posedge clk); @(negedge clk);
    check("mid_rsp0_valid",  32'(bus.rsp0_valid),  32'd1);
    check("mid_rsp0_result", 32'(bus.rsp0_result), 32'b0111);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("mid_rst_busy",       32'(busy), 32'd0);
    check("mid_rst_results",    32'({bus.rsp0_result, bus.rsp1_result}), 32'd0);
    check("mid_rst_alu_inputs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("mid_rst_op_count",   32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    single_op(1'b0, 4'b0011, 4'b0100, 3'b000, 4'b0111);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
